// File: rtl/addr_transfer_reg_pkg.sv
// Shared LVDC definitions for the address transfer register: syllable
// geometry defaults, the deserializer state encoding and a counter sizing helper.
package addr_transfer_reg_pkg;

  localparam int SYL_BITS_DEF  = 13;
  localparam int OP_BITS_DEF   = 4;
  localparam int ADDR_BITS_DEF = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Width of a counter able to index every bit of a syllable.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addr_transfer_reg_if.sv
// Serial syllable input, transfer handshake and held-syllable outputs of the
// address transfer register. The slave side is the register itself.
interface addr_transfer_reg_if
  import addr_transfer_reg_pkg::*;
#(
  parameter int OP_BITS   = OP_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
);
  logic                 SER_IN;
  logic                 BIT_EN;
  logic                 WORD_START;
  logic                 TR_TAKE;
  logic                 CLR_ERR;
  logic [OP_BITS-1:0]   OP_OUT;
  logic [ADDR_BITS-1:0] TR_OUT;
  logic                 TR_VALID;
  logic                 OVERRUN;
  logic                 SYNC_ERR;

  modport master (
    output SER_IN, BIT_EN, WORD_START, TR_TAKE, CLR_ERR,
    input  OP_OUT, TR_OUT, TR_VALID, OVERRUN, SYNC_ERR
  );

  modport slave (
    input  SER_IN, BIT_EN, WORD_START, TR_TAKE, CLR_ERR,
    output OP_OUT, TR_OUT, TR_VALID, OVERRUN, SYNC_ERR
  );
endinterface

// File: rtl/addr_transfer_reg_serial_bit_counter.sv
// Bit position counter for the syllable deserializer. WORD_START restarts it
// at 1 (bit 0 is taken in the same strobe); tc flags the last bit position.
module serial_bit_counter #(
  parameter int SYL_BITS = 13,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             word_start,
  input  logic             active,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc  = active && (cnt_q == CNT_W'(SYL_BITS - 1));
  assign cnt = cnt_q;

  // Next count: restart on WORD_START, advance on strobes while shifting, wrap after the last bit.
  always_comb begin
    cnt_d = cnt_q;
    if (bit_en && word_start) begin
      cnt_d = CNT_W'(1);
    end else if (bit_en && active) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/addr_transfer_reg.sv
// Address transfer register: deserializes LSB-first syllables into a shift
// buffer and, one cycle after the last bit, hands the op code and address to
// a held output stage that waits for the downstream register to take it.
//
// state    | meaning
// ST_IDLE  | waiting for WORD_START; plain bit strobes are ignored
// ST_SHIFT | collecting bits 1..SYL_BITS-1 of a syllable
module addr_transfer_reg
  import addr_transfer_reg_pkg::*;
#(
  parameter int SYL_BITS  = SYL_BITS_DEF,
  parameter int OP_BITS   = OP_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input logic                CLK,
  input logic                RESETN,
  addr_transfer_reg_if.slave bus
);

  localparam int CNT_W = cnt_width(SYL_BITS);

  state_e               state_q, state_d;
  logic [SYL_BITS-1:0]  shbuf_q, shbuf_d;
  logic                 done_q, done_d;
  logic [OP_BITS-1:0]   op_q, op_d;
  logic [ADDR_BITS-1:0] tr_q, tr_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 sync_q, sync_d;
  logic                 ovr_set, sync_set;
  logic [CNT_W-1:0]     cnt;
  logic                 tc;
  logic                 shifting;
  logic                 restart;

  assign shifting = (state_q == ST_SHIFT);
  assign restart  = bus.BIT_EN && bus.WORD_START;

  serial_bit_counter #(
    .SYL_BITS (SYL_BITS),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .clk        (CLK),
    .rst_n      (RESETN),
    .bit_en     (bus.BIT_EN),
    .word_start (bus.WORD_START),
    .active     (shifting),
    .cnt        (cnt),
    .tc         (tc)
  );

  // Deserializer FSM: restart on WORD_START, shift on strobes, flag completion on the last bit.
  always_comb begin
    state_d  = state_q;
    shbuf_d  = shbuf_q;
    done_d   = 1'b0;
    sync_set = 1'b0;
    if (restart) begin
      state_d    = ST_SHIFT;
      shbuf_d    = '0;
      shbuf_d[0] = bus.SER_IN;
      sync_set   = shifting;
    end else if (bus.BIT_EN && shifting) begin
      shbuf_d[cnt] = bus.SER_IN;
      if (tc) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // Held stage: load a completed syllable when free or being taken, otherwise flag overrun.
  always_comb begin
    op_d    = op_q;
    tr_d    = tr_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (done_q) begin
      if (!valid_q || bus.TR_TAKE) begin
        op_d    = shbuf_q[OP_BITS-1:0];
        tr_d    = shbuf_q[SYL_BITS-1:OP_BITS];
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (bus.TR_TAKE) begin
      valid_d = 1'b0;
    end
    ovr_d  = ovr_set  || (ovr_q  && !bus.CLR_ERR);
    sync_d = sync_set || (sync_q && !bus.CLR_ERR);
  end

  // State, buffer and output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      shbuf_q <= '0;
      done_q  <= 1'b0;
      op_q    <= '0;
      tr_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shbuf_q <= shbuf_d;
      done_q  <= done_d;
      op_q    <= op_d;
      tr_q    <= tr_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.OP_OUT   = op_q;
  assign bus.TR_OUT   = tr_q;
  assign bus.TR_VALID = valid_q;
  assign bus.OVERRUN  = ovr_q;
  assign bus.SYNC_ERR = sync_q;

endmodule

// File: doc/addr_transfer_reg.md
ADDR_TRANSFER_REG -- requirements
Module: addr_transfer_reg

Interface
REQ-001 SHALL have parameter SYL_BITS, default 13, meaning serial syllable length in bits.
REQ-002 SHALL have parameter OP_BITS, default 4, meaning op-code field width (syllable bits 0..OP_BITS-1).
REQ-003 SHALL have parameter ADDR_BITS, default 9, meaning address field width (bits OP_BITS..SYL_BITS-1, feeding A1..A9 load paths).
REQ-004 SHALL have: CLK  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have: RESETN  input  1  asynchronous active-low reset.
REQ-006 SHALL have: SER_IN  input  1  serial syllable data, LSB first.
REQ-007 SHALL have: BIT_EN  input  1  bit-time strobe; SER_IN is sampled only when high.
REQ-008 SHALL have: WORD_START  input  1  marks bit 0 of a syllable; qualified by BIT_EN.
REQ-009 SHALL have: TR_TAKE  input  1  downstream address register has loaded TR (Z1/Z2 transfer done).
REQ-010 SHALL have: CLR_ERR  input  1  clears sticky error flags.
REQ-011 SHALL have: OP_OUT  output  OP_BITS  held op code (OP1 = bit 0).
REQ-012 SHALL have: TR_OUT  output  ADDR_BITS  held address, TR_OUT[0] = TR1V ... TR_OUT[8] = TR9V.
REQ-013 SHALL have: TR_VALID  output  1  OP_OUT/TR_OUT hold an untaken syllable.
REQ-014 SHALL have: OVERRUN  output  1  sticky, syllable completed while TR_VALID high and not taken.
REQ-015 SHALL have: SYNC_ERR  output  1  sticky, WORD_START seen mid-syllable.

Function
REQ-016 SHALL implement states IDLE, SHIFT; BIT_EN with WORD_START in any state enters SHIFT, samples SER_IN as bit 0, sets bit counter to 1.
REQ-017 SHALL in SHIFT, on each BIT_EN without WORD_START, shift SER_IN into bit position given by counter and increment counter.
REQ-018 SHALL, on the BIT_EN sampling bit SYL_BITS-1, return to IDLE and mark syllable complete; TR_VALID rises on the next CLK edge (latency 1 cycle after last bit sample).
REQ-019 SHALL ignore BIT_EN without WORD_START in IDLE (no shift, no counter change).
REQ-020 SHALL, on WORD_START while in SHIFT with counter 1..SYL_BITS-1, discard the partial syllable, set SYNC_ERR, restart at bit 0 with current SER_IN.
REQ-021 SHALL update OP_OUT/TR_OUT only at syllable completion when TR_VALID is low or TR_TAKE is high that cycle; outputs otherwise hold.
REQ-022 SHALL clear TR_VALID on TR_TAKE; TR_TAKE with TR_VALID low is ignored.
REQ-023 SHALL, on completion coincident with TR_TAKE, load the new syllable and keep TR_VALID high, OVERRUN unchanged.
REQ-024 SHALL, on completion with TR_VALID high and no TR_TAKE, discard the new syllable, keep held outputs, set OVERRUN.
REQ-025 SHALL clear OVERRUN and SYNC_ERR on CLR_ERR; a set event in the same cycle wins.
REQ-026 SHALL keep the shift buffer separate from OP_OUT/TR_OUT so a new syllable shifts while the previous one is held.

Reset
REQ-027 SHALL on RESETN low immediately force state IDLE, counter 0, shift buffer 0, OP_OUT 0, TR_OUT 0, TR_VALID 0, OVERRUN 0, SYNC_ERR 0.
REQ-028 SHALL abandon any partial syllable on reset; first syllable after release requires WORD_START.

Structure
REQ-029 SHALL place SYL_BITS/OP_BITS/ADDR_BITS defaults and the state encoding in the shared LVDC package.
REQ-030 SHALL contain one natural sub-module, serial_bit_counter (counter, WORD_START restart, terminal-count flag); all else inline.

Verification
REQ-031 SHALL check: WORD_START + 13 BIT_EN bits, syllable 0x1A53 LSB first -> one cycle later TR_VALID=1, OP_OUT=0x3, TR_OUT=0x1A5.
REQ-032 SHALL check: TR_TAKE one cycle after TR_VALID -> TR_VALID=0 next edge, outputs hold 0x3/0x1A5.
REQ-033 SHALL check: two syllables 0x0001, 0x1FFF without TR_TAKE -> OVERRUN=1, OP_OUT=0x1, TR_OUT=0x000.
REQ-034 SHALL check: second syllable completes same cycle as TR_TAKE -> TR_VALID stays 1, OP_OUT=0xF, TR_OUT=0x1FF, OVERRUN=0.
REQ-035 SHALL check: WORD_START at bit 7 then 13 bits of 0x0AAA -> SYNC_ERR=1, TR_OUT=0x0AA, OP_OUT=0xA.
REQ-036 SHALL check: RESETN low at bit 5 with TR_VALID high -> all outputs 0 asynchronously; bits without WORD_START after release ignored.
